// File: rtl/vivaldi_pkg.sv
// vivaldi_pkg
//   Shared definitions for the vivaldi synthesizer audio path.
//   SAMPLE_WIDTH        : native PCM sample width in bits.
//   sample_t            : signed two's-complement PCM sample.
//   I2S_CLK_DIV_DEFAULT : default clk cycles per BCLK half-period.
package vivaldi_pkg;

  localparam int SAMPLE_WIDTH        = 24;
  localparam int I2S_CLK_DIV_DEFAULT = 4;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/vivaldi_i2s_clkgen.sv
// vivaldi_i2s_clkgen
//   Divides clk_i down to the I2S bit clock and flags the falling edge.
//   Ports:
//     clk_i   in  : system clock, rising edge.
//     rst_ni  in  : synchronous active-low reset.
//     bclk_o  out : bit clock, CLK_DIV clk_i cycles per half-period.
//     fall_o  out : high in the clk_i cycle whose edge drives bclk_o 1 -> 0.
module vivaldi_i2s_clkgen
  import vivaldi_pkg::*;
#(
  parameter int CLK_DIV = I2S_CLK_DIV_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic bclk_o,
  output logic fall_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             tc;

  always_comb begin
    tc     = (div_q == DIV_LAST);
    div_d  = tc ? '0 : div_q + DIV_W'(1);
    bclk_d = tc ? ~bclk_q : bclk_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk_o = bclk_q;
  // Strobe is combinational so that serial state moves on the same edge as BCLK falls.
  assign fall_o = tc && bclk_q;

endmodule

// File: rtl/vivaldi_i2s_tx.sv
// vivaldi_i2s_tx
//   Philips I2S transmitter: takes mono signed PCM samples over valid/ready
//   and plays each one in both the left and right slot of a frame.
//   Ports:
//     clk_i      in  : system clock, rising edge.
//     rst_ni     in  : synchronous active-low reset.
//     sample_i   in  : signed sample, WIDTH bits.
//     valid_i    in  : sample_i is valid.
//     ready_o    out : holding register empty, a sample can be accepted.
//     bclk_o     out : I2S bit clock.
//     lrclk_o    out : word select, 0 = left slot, 1 = right slot.
//     sdata_o    out : serial data, MSB first, changes on BCLK falling edge.
//     underrun_o out : one-cycle pulse when a frame starts with no sample held.
module vivaldi_i2s_tx
  import vivaldi_pkg::*;
#(
  parameter int WIDTH   = SAMPLE_WIDTH,
  parameter int CLK_DIV = I2S_CLK_DIV_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic signed [WIDTH-1:0] sample_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic                    bclk_o,
  output logic                    lrclk_o,
  output logic                    sdata_o,
  output logic                    underrun_o
);

  localparam int FRAME_BITS = 2 * WIDTH;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam int IW         = $clog2(WIDTH);
  localparam logic [BW-1:0] B_LAST = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] B_SLOT = BW'(WIDTH);

  logic fall;

  vivaldi_i2s_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bclk_o (bclk_o),
    .fall_o (fall)
  );

  logic signed [WIDTH-1:0] hold_q, hold_d;
  logic signed [WIDTH-1:0] frame_q, frame_d;
  logic                    full_q, full_d;
  logic [BW-1:0]           b_q, b_d;
  logic                    sdata_q, sdata_d;
  logic                    lrclk_q, lrclk_d;
  logic                    underrun_q, underrun_d;

  logic          accept;
  logic          frame_start;
  logic [BW-1:0] b_nxt;
  logic [BW-1:0] slot_bit;
  logic [IW-1:0] sel;

  always_comb begin
    accept      = valid_i && !full_q;
    frame_start = fall && (b_q == B_LAST);
    b_nxt       = (b_q == B_LAST) ? '0 : b_q + BW'(1);

    // Holding register: frame start can only clear full while it is set, and
    // accept only happens while it is clear, so the two never collide.
    hold_d = accept ? sample_i : hold_q;
    full_d = full_q;
    if (frame_start) full_d = 1'b0;
    if (accept)      full_d = 1'b1;

    // No bypass: the frame only ever sees what was held before this edge.
    frame_d = frame_q;
    if (frame_start) frame_d = full_q ? hold_q : '0;

    b_d = fall ? b_nxt : b_q;

    // Both slots carry the same sample, so the bit index folds onto one slot.
    slot_bit = (b_nxt >= B_SLOT) ? (b_nxt - B_SLOT) : b_nxt;
    sel      = IW'(WIDTH - 1) - IW'(slot_bit);

    sdata_d = fall ? frame_d[sel] : sdata_q;
    // Word select is high for bits WIDTH-1 .. 2*WIDTH-2, one BCLK ahead of its slot.
    lrclk_d = fall ? ((b_nxt >= (B_SLOT - BW'(1))) && (b_nxt != B_LAST)) : lrclk_q;

    underrun_d = frame_start && !full_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_q     <= '0;
      frame_q    <= '0;
      full_q     <= 1'b0;
      b_q        <= B_LAST;
      sdata_q    <= 1'b0;
      lrclk_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      frame_q    <= frame_d;
      full_q     <= full_d;
      b_q        <= b_d;
      sdata_q    <= sdata_d;
      lrclk_q    <= lrclk_d;
      underrun_q <= underrun_d;
    end
  end

  assign ready_o    = !full_q;
  assign sdata_o    = sdata_q;
  assign lrclk_o    = lrclk_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_vivaldi_i2s_tx.sv
module tb_vivaldi_i2s_tx;

  logic        clk;
  logic        rst_n;
  logic [23:0] sample;
  logic        valid;
  logic        ready;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        underrun;

  int total = 0;
  int bad   = 0;

  vivaldi_i2s_tx #(
    .WIDTH   (24),
    .CLK_DIV (2)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .sample_i   (sample),
    .valid_i    (valid),
    .ready_o    (ready),
    .bclk_o     (bclk),
    .lrclk_o    (lrclk),
    .sdata_o    (sdata),
    .underrun_o (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    sample = 24'h0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Called right after a frame-start edge; walks all 48 bit times and ends
  // right after the next frame-start edge. With feed set, the sample already
  // on sample_i must be accepted one cycle into the frame and then next_smp
  // is presented.
  task automatic check_frame(input string tag, input logic [23:0] exp,
                             input logic exp_ur, input logic feed,
                             input logic [23:0] next_smp);
    int ur_cnt;
    ur_cnt = 0;
    for (int i = 0; i < 48; i++) begin
      chk($sformatf("%s sdata bit %0d", tag, i), sdata, exp[23 - (i % 24)]);
      chk($sformatf("%s lrclk bit %0d", tag, i), lrclk, (((i + 1) % 48) >= 24));
      chk($sformatf("%s bclk bit %0d", tag, i), bclk, 1'b0);
      if (i == 0) chk($sformatf("%s underrun at start", tag), underrun, exp_ur);
      if (feed) chk($sformatf("%s ready bit %0d", tag, i), ready, (i == 0));
      ur_cnt += int'(underrun);
      for (int k = 1; k < 4; k++) begin
        tick();
        ur_cnt += int'(underrun);
        if (feed && i == 0 && k == 1) begin
          chk($sformatf("%s ready after accept", tag), ready, 1'b0);
          sample = next_smp;
        end
      end
      tick();
    end
    chk($sformatf("%s underrun count", tag), ur_cnt, {31'b0, exp_ur});
  endtask

  initial begin
    rst_n  = 1'b0;
    valid  = 1'b0;
    sample = 24'h0;

    // 1: reset hold, release, first BCLK fall at cycle 4 with underrun
    tick(); tick(); tick();
    chk("rst bclk", bclk, 1'b0);
    chk("rst lrclk", lrclk, 1'b0);
    chk("rst sdata", sdata, 1'b0);
    chk("rst underrun", underrun, 1'b0);
    chk("rst ready", ready, 1'b1);
    rst_n = 1'b1;
    tick();
    chk("c1 bclk", bclk, 1'b0);
    tick();
    chk("c2 bclk", bclk, 1'b1);
    tick();
    chk("c3 bclk", bclk, 1'b1);
    chk("c3 underrun", underrun, 1'b0);
    tick();
    chk("c4 underrun", underrun, 1'b1);
    check_frame("t1 f0", 24'h000000, 1'b1, 1'b0, 24'h0);

    // 2 + 4: one sample 0x800001, then idle frames of zeros with one underrun each
    do_reset();
    valid = 1'b1;
    sample = 24'h800001;
    chk("t2 ready before", ready, 1'b1);
    tick();
    valid = 1'b0;
    chk("t2 ready held", ready, 1'b0);
    tick(); tick(); tick();
    check_frame("t2 f1", 24'h800001, 1'b0, 1'b0, 24'h0);
    check_frame("t4 idle1", 24'h000000, 1'b1, 1'b0, 24'h0);
    check_frame("t4 idle2", 24'h000000, 1'b1, 1'b0, 24'h0);

    // 3: valid held high with samples 1, 2, 3
    do_reset();
    valid = 1'b1;
    sample = 24'h000001;
    chk("t3 ready first", ready, 1'b1);
    tick();
    chk("t3 ready after 1", ready, 1'b0);
    sample = 24'h000002;
    tick(); tick(); tick();
    check_frame("t3 s1", 24'h000001, 1'b0, 1'b1, 24'h000003);
    check_frame("t3 s2", 24'h000002, 1'b0, 1'b1, 24'h000003);
    valid = 1'b0;
    check_frame("t3 s3", 24'h000003, 1'b0, 1'b0, 24'h0);
    check_frame("t3 after", 24'h000000, 1'b1, 1'b0, 24'h0);

    // 5: sample arrives on the frame-start cycle with the register empty
    do_reset();
    tick(); tick(); tick();
    valid = 1'b1;
    sample = 24'h123456;
    tick();
    valid = 1'b0;
    chk("t5 ready held", ready, 1'b0);
    check_frame("t5 zero", 24'h000000, 1'b1, 1'b0, 24'h0);
    check_frame("t5 late", 24'h123456, 1'b0, 1'b0, 24'h0);

    // 6: reset at the 10th bit of the right slot with a sample held
    do_reset();
    valid = 1'b1;
    sample = 24'h5A5A5A;
    tick();
    valid = 1'b0;
    tick(); tick(); tick();
    chk("t6 ready at start", ready, 1'b1);
    valid = 1'b1;
    sample = 24'hFFFFFF;
    tick();
    valid = 1'b0;
    chk("t6 held", ready, 1'b0);
    repeat (131) tick();
    chk("t6 right bit9 lrclk", lrclk, 1'b1);
    chk("t6 right bit9 sdata", sdata, 1'b1);
    chk("t6 right bit9 bclk", bclk, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("t6 rst bclk", bclk, 1'b0);
    chk("t6 rst lrclk", lrclk, 1'b0);
    chk("t6 rst sdata", sdata, 1'b0);
    chk("t6 rst underrun", underrun, 1'b0);
    chk("t6 rst ready", ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    check_frame("t6 after rst", 24'h000000, 1'b1, 1'b0, 24'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
